// File: rtl/ctrl_resolve_pipe.sv
// Registered control-transfer resolution for the integer execute stage.
// Resolves up to LANES jumps/branches/returns per cycle and holds the oldest mispredict as a redirect.
module ctrl_resolve_pipe #(
    parameter int DATA_W   = 32,
    parameter int PC_W     = 32,
    parameter int IMM_W    = 16,
    parameter int TARGET_W = 26,
    parameter int LANES    = 2,
    parameter int TAG_W    = 7
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush_i,
    input  logic [LANES-1:0]        valid_i,
    input  logic [4*LANES-1:0]      op_i,
    input  logic [DATA_W*LANES-1:0] data1_i,
    input  logic [DATA_W*LANES-1:0] data2_i,
    input  logic [IMM_W*LANES-1:0]  immd_i,
    input  logic [PC_W*LANES-1:0]   pc_i,
    input  logic [PC_W*LANES-1:0]   predNPC_i,
    input  logic [LANES-1:0]        predDir_i,
    input  logic [TAG_W*LANES-1:0]  tag_i,
    output logic [LANES-1:0]        valid_o,
    output logic [PC_W*LANES-1:0]   result_o,
    output logic [PC_W*LANES-1:0]   nextPC_o,
    output logic [LANES-1:0]        direction_o,
    output logic [5*LANES-1:0]      flags_o,
    output logic                    redir_valid_o,
    output logic [PC_W-1:0]         redir_pc_o,
    output logic [TAG_W-1:0]        redir_tag_o,
    input  logic                    redir_ready_i
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,  OP_JUMP = 4'd1,  OP_JAL  = 4'd2,  OP_JR   = 4'd3,
        OP_JALR = 4'd4,  OP_BEQ  = 4'd5,  OP_BNE  = 4'd6,  OP_BLEZ = 4'd7,
        OP_BGTZ = 4'd8,  OP_BLTZ = 4'd9,  OP_BGEZ = 4'd10, OP_RET  = 4'd11
    } op_e;

    // Tags carry a wrap bit, so age is the sign of the modular difference.
    function automatic logic is_older(input logic [TAG_W-1:0] a, input logic [TAG_W-1:0] b);
        logic [TAG_W-1:0] diff;
        diff = a - b;
        return diff[TAG_W-1];
    endfunction

    logic [LANES-1:0]      valid_d, valid_q;
    logic [PC_W*LANES-1:0] result_d, result_q;
    logic [PC_W*LANES-1:0] npc_d, npc_q;
    logic [LANES-1:0]      dir_d, dir_q;
    logic [5*LANES-1:0]    flags_d, flags_q;
    logic                  redir_valid_d, redir_valid_q;
    logic [PC_W-1:0]       redir_pc_d, redir_pc_q;
    logic [TAG_W-1:0]      redir_tag_d, redir_tag_q;
    logic                  cand_valid;
    logic [PC_W-1:0]       cand_pc;
    logic [TAG_W-1:0]      cand_tag;

    always_comb begin
        logic [3:0]        op;
        logic [DATA_W-1:0] a, b;
        logic [IMM_W-1:0]  imm;
        logic [PC_W-1:0]   pc, pnpc, pc8, br_tgt, j_tgt, a_pc, res, npc;
        logic [TAG_W-1:0]  tag;
        logic              dir, mis, a_neg, a_zero;
        logic [4:0]        fl;
        op = '0; a = '0; b = '0; imm = '0; pc = '0; pnpc = '0; pc8 = '0;
        br_tgt = '0; j_tgt = '0; a_pc = '0; res = '0; npc = '0; tag = '0;
        dir = 1'b0; mis = 1'b0; a_neg = 1'b0; a_zero = 1'b0; fl = '0;
        valid_d = '0; result_d = '0; npc_d = '0; dir_d = '0; flags_d = '0;
        cand_valid = 1'b0; cand_pc = '0; cand_tag = '0;
        for (int i = 0; i < LANES; i++) begin
            op     = op_i[i*4 +: 4];
            a      = data1_i[i*DATA_W +: DATA_W];
            b      = data2_i[i*DATA_W +: DATA_W];
            imm    = immd_i[i*IMM_W +: IMM_W];
            pc     = pc_i[i*PC_W +: PC_W];
            pnpc   = predNPC_i[i*PC_W +: PC_W];
            tag    = tag_i[i*TAG_W +: TAG_W];
            pc8    = pc + PC_W'(8);
            br_tgt = pc8 + {{(PC_W-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
            j_tgt  = pc;
            j_tgt[TARGET_W+1:0] = {pnpc[TARGET_W-1:0], 2'b00};
            a_pc   = PC_W'(a);
            a_neg  = a[DATA_W-1];
            a_zero = (a == '0);
            res = '0; npc = '0; dir = 1'b0; mis = 1'b0; fl = '0;
            // flags layout: {isPredicted, isControl, destValid, mispredict, executed}
            case (op)
                OP_NOP:  fl = 5'b00001;
                OP_JUMP: begin dir = 1'b1; npc = j_tgt; fl = 5'b01001; end
                OP_JAL:  begin dir = 1'b1; npc = j_tgt; res = pc8; fl = 5'b01101; end
                OP_JR, OP_JALR: begin
                    dir = 1'b1;
                    npc = a_pc;
                    mis = (a_pc != pnpc);
                    res = (op == OP_JALR) ? pc8 : '0;
                    fl  = {2'b01, op == OP_JALR, mis, 1'b1};
                end
                OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ, OP_BGEZ: begin
                    case (op)
                        OP_BEQ:  dir = (a == b);
                        OP_BNE:  dir = (a != b);
                        OP_BLEZ: dir = a_neg | a_zero;
                        OP_BGTZ: dir = ~a_neg & ~a_zero;
                        OP_BLTZ: dir = a_neg;
                        default: dir = ~a_neg;
                    endcase
                    npc = dir ? br_tgt : pc8;
                    mis = (dir != predDir_i[i]);
                    fl  = {3'b110, mis, 1'b1};
                end
                OP_RET: begin
                    dir = 1'b1;
                    npc = a_pc;
                    mis = (a_pc != pnpc);
                    fl  = {3'b110, mis, 1'b1};
                end
                default: fl = '0;
            endcase
            if (valid_i[i] && !flush_i) begin
                valid_d[i]              = 1'b1;
                result_d[i*PC_W +: PC_W] = res;
                npc_d[i*PC_W +: PC_W]    = npc;
                dir_d[i]                = dir;
                flags_d[i*5 +: 5]       = fl;
            end
            // Strictly-older comparison keeps the lowest lane on equal ages.
            if (valid_i[i] && !flush_i && mis && (!cand_valid || is_older(tag, cand_tag))) begin
                cand_valid = 1'b1;
                cand_pc    = npc;
                cand_tag   = tag;
            end
        end
    end

    // Single-entry redirect: flush clears, handshake drains, otherwise only an older mispredict displaces it.
    always_comb begin
        redir_valid_d = redir_valid_q;
        redir_pc_d    = redir_pc_q;
        redir_tag_d   = redir_tag_q;
        if (flush_i) begin
            redir_valid_d = 1'b0;
            redir_pc_d    = '0;
            redir_tag_d   = '0;
        end else if (redir_valid_q && redir_ready_i) begin
            redir_valid_d = 1'b0;
            if (cand_valid && is_older(cand_tag, redir_tag_q)) begin
                redir_valid_d = 1'b1;
                redir_pc_d    = cand_pc;
                redir_tag_d   = cand_tag;
            end
        end else if (cand_valid && (!redir_valid_q || is_older(cand_tag, redir_tag_q))) begin
            redir_valid_d = 1'b1;
            redir_pc_d    = cand_pc;
            redir_tag_d   = cand_tag;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q       <= '0;
            result_q      <= '0;
            npc_q         <= '0;
            dir_q         <= '0;
            flags_q       <= '0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            redir_tag_q   <= '0;
        end else begin
            valid_q       <= valid_d;
            result_q      <= result_d;
            npc_q         <= npc_d;
            dir_q         <= dir_d;
            flags_q       <= flags_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            redir_tag_q   <= redir_tag_d;
        end
    end

    assign valid_o       = valid_q;
    assign result_o      = result_q;
    assign nextPC_o      = npc_q;
    assign direction_o   = dir_q;
    assign flags_o       = flags_q;
    assign redir_valid_o = redir_valid_q;
    assign redir_pc_o    = redir_pc_q;
    assign redir_tag_o   = redir_tag_q;

endmodule

// File: tb/tb_ctrl_resolve_pipe.sv
// Scoreboard bench for ctrl_resolve_pipe: expected lane results are queued at drive time
// and popped one cycle later; a reference redirect register tracks the held channel.
module tb_ctrl_resolve_pipe;

    localparam int DATA_W = 32, PC_W = 32, IMM_W = 16, TARGET_W = 26, LANES = 2, TAG_W = 7;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic                    flush_i;
    logic [LANES-1:0]        valid_i;
    logic [4*LANES-1:0]      op_i;
    logic [DATA_W*LANES-1:0] data1_i, data2_i;
    logic [IMM_W*LANES-1:0]  immd_i;
    logic [PC_W*LANES-1:0]   pc_i, predNPC_i;
    logic [LANES-1:0]        predDir_i;
    logic [TAG_W*LANES-1:0]  tag_i;
    logic [LANES-1:0]        valid_o;
    logic [PC_W*LANES-1:0]   result_o, nextPC_o;
    logic [LANES-1:0]        direction_o;
    logic [5*LANES-1:0]      flags_o;
    logic                    redir_valid_o;
    logic [PC_W-1:0]         redir_pc_o;
    logic [TAG_W-1:0]        redir_tag_o;
    logic                    redir_ready_i;

    ctrl_resolve_pipe #(.DATA_W(DATA_W), .PC_W(PC_W), .IMM_W(IMM_W), .TARGET_W(TARGET_W),
                        .LANES(LANES), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset_n(reset_n), .flush_i(flush_i), .valid_i(valid_i), .op_i(op_i),
        .data1_i(data1_i), .data2_i(data2_i), .immd_i(immd_i), .pc_i(pc_i),
        .predNPC_i(predNPC_i), .predDir_i(predDir_i), .tag_i(tag_i), .valid_o(valid_o),
        .result_o(result_o), .nextPC_o(nextPC_o), .direction_o(direction_o), .flags_o(flags_o),
        .redir_valid_o(redir_valid_o), .redir_pc_o(redir_pc_o), .redir_tag_o(redir_tag_o),
        .redir_ready_i(redir_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LANES-1:0]      v;
        logic [PC_W*LANES-1:0] res;
        logic [PC_W*LANES-1:0] npc;
        logic [LANES-1:0]      dir;
        logic [5*LANES-1:0]    flags;
    } exp_t;

    exp_t            exp_q[$];
    int              error_count = 0;
    int              check_count = 0;
    logic            m_rv;
    logic [PC_W-1:0] m_rpc;
    logic [TAG_W-1:0] m_rtag;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic older(input logic [TAG_W-1:0] a, input logic [TAG_W-1:0] b);
        logic [TAG_W-1:0] d;
        d = a - b;
        return d[TAG_W-1];
    endfunction

    // Reference lane model written from the op table using signed arithmetic.
    task automatic modelLane(input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2,
                             input logic [15:0] imm, input logic [31:0] pc, input logic [31:0] pn,
                             input logic pd, output logic [31:0] r, output logic [31:0] n,
                             output logic d, output logic [4:0] f);
        logic signed [31:0] off;
        logic [31:0] bt, jt;
        logic taken, m;
        off = $signed(imm);
        bt  = pc + 32'd8 + (off <<< 2);
        jt  = {pc[31:28], pn[25:0], 2'b00};
        r = 0; n = 0; d = 0; f = 0; taken = 0; m = 0;
        case (op)
            4'd0: f = 5'b00001;
            4'd1: begin d = 1; n = jt; f = 5'b01001; end
            4'd2: begin d = 1; n = jt; r = pc + 8; f = 5'b01101; end
            4'd3: begin d = 1; n = d1; m = (d1 != pn); f = {4'b0100, 1'b1} | {3'b0, m, 1'b0}; end
            4'd4: begin d = 1; n = d1; r = pc + 8; m = (d1 != pn); f = 5'b01101 | {3'b0, m, 1'b0}; end
            4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10: begin
                if (op == 4'd5)      taken = (d1 == d2);
                else if (op == 4'd6) taken = (d1 != d2);
                else if (op == 4'd7) taken = ($signed(d1) <= 0);
                else if (op == 4'd8) taken = ($signed(d1) > 0);
                else if (op == 4'd9) taken = ($signed(d1) < 0);
                else                 taken = ($signed(d1) >= 0);
                d = taken; n = taken ? bt : pc + 8; m = (taken != pd);
                f = 5'b11001 | {3'b0, m, 1'b0};
            end
            4'd11: begin d = 1; n = d1; m = (d1 != pn); f = 5'b11001 | {3'b0, m, 1'b0}; end
            default: f = 0;
        endcase
    endtask

    task automatic setLane(input int i, input logic [3:0] op, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [15:0] imm, input logic [31:0] pc,
                           input logic [31:0] pn, input logic pd, input logic [6:0] tag);
        valid_i[i] = 1'b1;
        op_i[i*4 +: 4] = op;
        data1_i[i*DATA_W +: DATA_W] = d1;
        data2_i[i*DATA_W +: DATA_W] = d2;
        immd_i[i*IMM_W +: IMM_W] = imm;
        pc_i[i*PC_W +: PC_W] = pc;
        predNPC_i[i*PC_W +: PC_W] = pn;
        predDir_i[i] = pd;
        tag_i[i*TAG_W +: TAG_W] = tag;
    endtask

    task automatic setIdle();
        valid_i = '0; op_i = '0; data1_i = '0; data2_i = '0; immd_i = '0;
        pc_i = '0; predNPC_i = '0; predDir_i = '0; tag_i = '0;
        flush_i = 1'b0; redir_ready_i = 1'b0;
    endtask

    // Drives one cycle: queue the expectation, step the redirect model, clock, then compare.
    task automatic applyStimulus();
        exp_t e;
        logic c_v;
        logic [PC_W-1:0] c_pc;
        logic [TAG_W-1:0] c_tag;
        e.v = '0; e.res = '0; e.npc = '0; e.dir = '0; e.flags = '0;
        c_v = 0; c_pc = 0; c_tag = 0;
        for (int i = 0; i < LANES; i++) begin
            logic [31:0] r, n;
            logic d;
            logic [4:0] f;
            modelLane(op_i[i*4 +: 4], data1_i[i*DATA_W +: DATA_W], data2_i[i*DATA_W +: DATA_W],
                      immd_i[i*IMM_W +: IMM_W], pc_i[i*PC_W +: PC_W], predNPC_i[i*PC_W +: PC_W],
                      predDir_i[i], r, n, d, f);
            if (valid_i[i] && !flush_i) begin
                e.v[i] = 1; e.res[i*PC_W +: PC_W] = r; e.npc[i*PC_W +: PC_W] = n;
                e.dir[i] = d; e.flags[i*5 +: 5] = f;
                if (f[1] && (!c_v || older(tag_i[i*TAG_W +: TAG_W], c_tag))) begin
                    c_v = 1; c_pc = n; c_tag = tag_i[i*TAG_W +: TAG_W];
                end
            end
        end
        if (flush_i) m_rv = 0;
        else if (m_rv && redir_ready_i) begin
            m_rv = 0;
            if (c_v && older(c_tag, m_rtag)) begin m_rv = 1; m_rpc = c_pc; m_rtag = c_tag; end
        end else if (c_v && (!m_rv || older(c_tag, m_rtag))) begin
            m_rv = 1; m_rpc = c_pc; m_rtag = c_tag;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checkOutput("valid_o", valid_o, e.v);
        checkOutput("result_o", result_o, e.res);
        checkOutput("nextPC_o", nextPC_o, e.npc);
        checkOutput("direction_o", direction_o, e.dir);
        checkOutput("flags_o", flags_o, e.flags);
        checkOutput("redir_valid_o", redir_valid_o, m_rv);
        if (m_rv) begin
            checkOutput("redir_pc_o", redir_pc_o, m_rpc);
            checkOutput("redir_tag_o", redir_tag_o, m_rtag);
        end
    endtask

    task automatic drainRedirect();
        setIdle();
        redir_ready_i = 1'b1;
        applyStimulus();
        setIdle();
    endtask

    initial begin
        m_rv = 0; m_rpc = 0; m_rtag = 0;
        setIdle();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", valid_o, 0);
        checkOutput("reset_result", result_o, 0);
        checkOutput("reset_npc", nextPC_o, 0);
        checkOutput("reset_flags", flags_o, 0);
        checkOutput("reset_redir", {redir_valid_o, redir_pc_o, redir_tag_o}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // JAL link and jump target
        setLane(0, 4'd2, 0, 0, 0, 32'h0040_0100, 32'h0010_0040, 0, 7'h01);
        applyStimulus();
        checkOutput("jal_result", result_o[31:0], 32'h0040_0108);
        checkOutput("jal_npc", nextPC_o[31:0], 32'h0040_0100);
        checkOutput("jal_flags", flags_o[4:0], 5'b01101);
        setIdle();

        // BNE not taken against taken prediction
        setLane(0, 4'd6, 5, 5, 16'hFFFF, 32'h1000, 0, 1, 7'h10);
        applyStimulus();
        checkOutput("bne_dir", direction_o[0], 0);
        checkOutput("bne_redir_pc", {redir_valid_o, redir_pc_o}, {1'b1, 32'h1008});
        drainRedirect();

        // RET: match then mismatch
        setLane(0, 4'd11, 32'h2000, 0, 0, 32'h500, 32'h2000, 1, 7'h11);
        applyStimulus();
        checkOutput("ret_match_redir", redir_valid_o, 0);
        setLane(0, 4'd11, 32'h2004, 0, 0, 32'h500, 32'h2000, 1, 7'h12);
        applyStimulus();
        checkOutput("ret_miss_redir", {redir_valid_o, redir_pc_o}, {1'b1, 32'h2004});
        drainRedirect();

        // Two-lane age selection, plain and wrapped
        setLane(0, 4'd3, 32'hA0, 0, 0, 32'h100, 32'hB0, 0, 7'h41);
        setLane(1, 4'd3, 32'hC0, 0, 0, 32'h104, 32'hD0, 0, 7'h3F);
        applyStimulus();
        checkOutput("age_tag", redir_tag_o, 7'h3F);
        drainRedirect();
        setLane(0, 4'd3, 32'hA0, 0, 0, 32'h100, 32'hB0, 0, 7'h7F);
        setLane(1, 4'd3, 32'hC0, 0, 0, 32'h104, 32'hD0, 0, 7'h01);
        applyStimulus();
        checkOutput("wrap_tag", redir_tag_o, 7'h7F);
        drainRedirect();

        // Hold, ignore younger, replace with older, then handshake
        setLane(0, 4'd3, 32'h300, 0, 0, 32'h100, 32'h0, 0, 7'h20);
        applyStimulus();
        setIdle();
        setLane(1, 4'd3, 32'h400, 0, 0, 32'h100, 32'h0, 0, 7'h25);
        applyStimulus();
        checkOutput("hold_younger_tag", {redir_tag_o, redir_pc_o}, {7'h20, 32'h300});
        setIdle();
        setLane(0, 4'd3, 32'h500, 0, 0, 32'h100, 32'h0, 0, 7'h18);
        applyStimulus();
        checkOutput("older_replace", {redir_tag_o, redir_pc_o}, {7'h18, 32'h500});
        setIdle();
        redir_ready_i = 1'b1;
        setLane(0, 4'd3, 32'h600, 0, 0, 32'h100, 32'h0, 0, 7'h10);
        applyStimulus();
        checkOutput("handshake_older_load", {redir_valid_o, redir_tag_o}, {1'b1, 7'h10});
        drainRedirect();
        checkOutput("handshake_clear", redir_valid_o, 0);

        // Flush drops pending redirect and same-cycle inputs
        setLane(0, 4'd3, 32'h700, 0, 0, 32'h100, 32'h0, 0, 7'h30);
        applyStimulus();
        setLane(0, 4'd3, 32'h800, 0, 0, 32'h100, 32'h0, 0, 7'h28);
        setLane(1, 4'd2, 0, 0, 0, 32'h100, 32'h40, 0, 7'h29);
        flush_i = 1'b1;
        applyStimulus();
        checkOutput("flush_redir", redir_valid_o, 0);
        checkOutput("flush_valid", valid_o, 0);
        setIdle();

        // Randomised traffic against the model
        for (int c = 0; c < 300; c++) begin
            setIdle();
            for (int i = 0; i < LANES; i++) begin
                logic [31:0] d1, pn;
                d1 = 32'(int'($urandom_range(0, 3)) - 1);
                pn = ($urandom_range(0, 1) == 1) ? d1 : 32'($urandom_range(0, 7));
                setLane(i, 4'($urandom_range(0, 15)), d1, 32'($urandom_range(0, 2)),
                        16'($urandom), $urandom, pn, 1'($urandom), 7'($urandom));
                valid_i[i] = 1'($urandom);
            end
            redir_ready_i = ($urandom_range(0, 2) == 0);
            flush_i = ($urandom_range(0, 9) == 0);
            applyStimulus();
        end

        // Asynchronous reset with a redirect pending
        setIdle();
        setLane(0, 4'd3, 32'h900, 0, 0, 32'h100, 32'h0, 0, 7'h05);
        applyStimulus();
        setIdle();
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_redir", redir_valid_o, 0);
        checkOutput("async_reset_valid", valid_o, 0);
        m_rv = 0;
        @(negedge clk);
        reset_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
